// File: rtl/led_chaser.sv
// Board LED pattern engine: debounced buttons drive a mode/speed/pause FSM that
// steps an N_LED-wide pattern on a prescaled tick; the top switch inverts the LEDs.
module led_chaser #(
  parameter int N_LED     = 16,
  parameter int N_SW      = 8,
  parameter int TICK_DIV  = 5000000,
  parameter int DB_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       btn,
  input  logic [N_SW-1:0]  sw,
  output logic [N_LED-1:0] ledr,
  output logic [1:0]       mode,
  output logic [1:0]       speed,
  output logic             paused
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DB_CYCLES);
  localparam logic [DW-1:0]    DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [N_LED-1:0] PAT_ONE = {{(N_LED-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    M_ROT_L  = 2'd0,
    M_ROT_R  = 2'd1,
    M_BOUNCE = 2'd2,
    M_FILL   = 2'd3
  } mode_e;

  logic [4:0]    sync1_q, sync2_q, lvl_q, lvl_prev_q, press;
  logic [DW-1:0] db_cnt_q [5];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      // Level flips only after DB_CYCLES consecutive disagreeing samples.
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_q[i] <= '0;
          lvl_q[i]    <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign press = lvl_q & ~lvl_prev_q;

  logic [N_LED-1:0] sw_ext;
  if (N_SW >= N_LED) begin : g_sw_trunc
    assign sw_ext = sw[N_LED-1:0];
  end else begin : g_sw_ext
    assign sw_ext = {{(N_LED-N_SW){1'b0}}, sw};
  end

  mode_e            mode_q, mode_d;
  logic [N_LED-1:0] pat_q, pat_d, step_pat;
  logic             dir_q, dir_d, step_dir;   // 0 = moving left
  logic [1:0]       speed_q, speed_d;
  logic             paused_q, paused_d;
  logic [CW-1:0]    count_q, count_d, cnt_last;
  logic [31:0]      per_full;
  logic             tick, reload_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= M_ROT_L;
      pat_q    <= PAT_ONE;
      dir_q    <= 1'b0;
      speed_q  <= 2'd0;
      paused_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    step_pat = pat_q;
    step_dir = dir_q;
    case (mode_q)
      M_ROT_L: step_pat = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
      M_ROT_R: step_pat = {pat_q[0], pat_q[N_LED-1:1]};
      M_BOUNCE: begin
        if (!dir_q) begin
          if (pat_q[N_LED-1]) begin
            step_pat = pat_q >> 1;
            step_dir = 1'b1;
          end else begin
            step_pat = pat_q << 1;
          end
        end else begin
          if (pat_q[0]) begin
            step_pat = pat_q << 1;
            step_dir = 1'b0;
          end else begin
            step_pat = pat_q >> 1;
          end
        end
      end
      M_FILL:  step_pat = (&pat_q) ? '0 : {pat_q[N_LED-2:0], 1'b1};
      default: step_pat = pat_q;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    pat_d    = pat_q;
    dir_d    = dir_q;
    speed_d  = speed_q;
    paused_d = paused_q ^ press[3];
    count_d  = count_q;

    per_full = 32'(TICK_DIV) >> speed_q;
    if (per_full == 32'd0) per_full = 32'd1;
    cnt_last  = CW'(per_full - 32'd1);
    tick      = (count_q == cnt_last) && !paused_q;
    reload_ok = press[4] && ((mode_q == M_ROT_L) || (mode_q == M_ROT_R));

    if (!paused_q) count_d = (count_q == cnt_last) ? '0 : count_q + CW'(1);

    // Priority: mode pulse, then an effective reload, then tick stepping and speed.
    if (press[0]) begin
      case (mode_q)
        M_ROT_L:  mode_d = M_ROT_R;
        M_ROT_R:  mode_d = M_BOUNCE;
        M_BOUNCE: mode_d = M_FILL;
        default:  mode_d = M_ROT_L;
      endcase
      pat_d   = PAT_ONE;
      dir_d   = 1'b0;
      count_d = '0;
    end else if (reload_ok) begin
      pat_d = (sw_ext == '0) ? PAT_ONE : sw_ext;
    end else begin
      if (tick) begin
        pat_d = step_pat;
        dir_d = step_dir;
      end
      if (press[1] && !press[2] && (speed_q != 2'd3)) begin
        speed_d = speed_q + 2'd1;
        count_d = '0;
      end else if (press[2] && !press[1] && (speed_q != 2'd0)) begin
        speed_d = speed_q - 2'd1;
        count_d = '0;
      end
    end
  end

  assign ledr   = pat_q ^ {N_LED{sw[N_SW-1]}};
  assign mode   = mode_q;
  assign speed  = speed_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser: directed scenarios plus random button/switch activity,
// every cycle compared against a behavioural model of the chaser.
module tb_led_chaser;
  localparam int N = 8, NSW = 8, TD = 8, DB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [4:0]     btn;
  logic [NSW-1:0] sw;
  logic [N-1:0]   ledr;
  logic [1:0]     mode, speed;
  logic           paused;

  always #5 clk = ~clk;

  led_chaser #(.N_LED(N), .N_SW(NSW), .TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw),
    .ledr(ledr), .mode(mode), .speed(speed), .paused(paused)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model: raw button history, debounced levels, and the pattern
  // held as a rotate value, a bounce position or a fill length.
  logic [4:0] m_hist[$];
  logic [4:0] m_lvl, m_prev;
  int m_mode, m_speed, m_count, m_rot, m_pos, m_dir, m_fill;
  bit m_paused;

  function automatic int model_pat();
    if (m_mode < 2)       return m_rot;
    else if (m_mode == 2) return 1 << m_pos;
    else                  return (1 << m_fill) - 1;
  endfunction

  function automatic logic [N-1:0] exp_ledr();
    int p;
    p = model_pat();
    return N'(p) ^ (sw[NSW-1] ? {N{1'b1}} : {N{1'b0}});
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < DB + 2; i++) m_hist.push_back(5'd0);
    m_lvl = '0; m_prev = '0;
    m_mode = 0; m_speed = 0; m_count = 0; m_paused = 1'b0;
    m_rot = 1; m_pos = 0; m_dir = 1; m_fill = 1;
  endtask

  task automatic model_advance();
    case (m_mode)
      0: m_rot = ((m_rot << 1) | (m_rot >> (N - 1))) & ((1 << N) - 1);
      1: m_rot = ((m_rot >> 1) | (m_rot << (N - 1))) & ((1 << N) - 1);
      2: begin
        m_pos += m_dir;
        if (m_pos == N - 1) m_dir = -1;
        else if (m_pos == 0) m_dir = 1;
      end
      default: m_fill = (m_fill + 1) % (N + 1);
    endcase
  endtask

  task automatic model_step();
    logic [4:0] pr;
    int per, v;
    bit tick, was_paused, diff;
    if (rst) begin
      model_reset();
      return;
    end
    pr = m_lvl & ~m_prev;
    m_prev = m_lvl;
    m_hist.push_front(btn);
    void'(m_hist.pop_back());
    for (int b = 0; b < 5; b++) begin
      diff = 1'b1;
      for (int i = 2; i < DB + 2; i++) if (m_hist[i][b] == m_lvl[b]) diff = 1'b0;
      if (diff) m_lvl[b] = ~m_lvl[b];
    end
    per = TD >> m_speed;
    if (per < 1) per = 1;
    tick = (m_count == per - 1) && !m_paused;
    was_paused = m_paused;
    m_paused = m_paused ^ pr[3];
    if (!was_paused) m_count = (m_count + 1) % per;
    if (pr[0]) begin
      m_mode = (m_mode + 1) % 4;
      m_rot = 1; m_pos = 0; m_dir = 1; m_fill = 1; m_count = 0;
    end else if (pr[4] && m_mode < 2) begin
      v = int'(sw) & ((1 << N) - 1);
      m_rot = (v == 0) ? 1 : v;
    end else begin
      if (tick) model_advance();
      if (pr[1] && !pr[2] && m_speed < 3) begin
        m_speed++; m_count = 0;
      end else if (pr[2] && !pr[1] && m_speed > 0) begin
        m_speed--; m_count = 0;
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ledr", ledr, exp_ledr());
      check("cyc_mode", mode, m_mode);
      check("cyc_speed", speed, m_speed);
      check("cyc_paused", paused, m_paused);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic [4:0] mask, input int hold);
    btn = mask;
    cyc(hold);
    btn = '0;
    cyc(8);
  endtask

  logic [N-1:0] held;

  initial begin
    rst = 1'b1; btn = '0; sw = '0;
    cyc(3);
    rst = 1'b0; chk_en = 1'b1;
    check("rst_ledr", ledr, 8'h01);
    check("rst_mode", mode, 0);
    check("rst_speed", speed, 0);
    check("rst_paused", paused, 0);
    cyc(7);  check("step_before", ledr, 8'h01);
    cyc(1);  check("step_first", ledr, 8'h02);
    cyc(48); check("step_msb", ledr, 8'h80);
    cyc(7);  check("hold_msb", ledr, 8'h80);
    cyc(1);  check("wrap_lsb", ledr, 8'h01);

    btn = 5'b00001;
    cyc(6);  check("mode_lat_before", mode, 0);
    cyc(1);  check("mode_rotr", mode, 1);
             check("mode_rotr_pat", ledr, 8'h01);
    cyc(3);  btn = '0;
    cyc(4);  check("rotr_before_tick", ledr, 8'h01);
    cyc(1);  check("rotr_first", ledr, 8'h80);
    cyc(8);  check("rotr_second", ledr, 8'h40);

    press(5'b00001, 6); check("mode_bounce", mode, 2);
    cyc(130);
    press(5'b00001, 6); check("mode_fill", mode, 3);
    cyc(20);
    press(5'b00001, 6); check("fill_to_rotl", mode, 0);
                        check("fill_to_rotl_pat", ledr, 8'h01);

    repeat (4) press(5'b00010, 6);
    check("speed_sat_hi", speed, 3);
    cyc(20);
    press(5'b00110, 6); check("speed_up_dn", speed, 3);
    repeat (4) press(5'b00100, 6);
    check("speed_sat_lo", speed, 0);

    press(5'b00001, 3); check("glitch_mode", mode, 0);

    sw = 8'h85; btn = 5'b10000;
    cyc(7);  check("reload_inv", ledr, 8'h7A);
    btn = '0; cyc(8);
    btn = 5'b01000;
    cyc(7);  check("pause_on", paused, 1);
    btn = '0;
    held = exp_ledr();
    cyc(100); check("pause_hold", ledr, held);
    press(5'b01000, 6); check("pause_off", paused, 0);

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0:       sw = NSW'($urandom);
        7:       press(5'b00110, $urandom_range(1, 10));
        8:       cyc($urandom_range(0, 30));
        9: begin
          if ($urandom_range(0, 3) == 0) begin
            rst = 1'b1; btn = '0;
            cyc(2);
            rst = 1'b0;
          end
        end
        default: press(5'(1 << $urandom_range(0, 4)), $urandom_range(1, 10));
      endcase
    end
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
